word_rx_ctrl: RTL and testbench

//  Sequencing controller for the two-byte receive register pair (reg1 = high byte, reg2 = low byte).

---
 rtl/word_rx_ctrl_pkg.sv | 18 +
 rtl/word_rx_ctrl_if.sv | 22 ++
 rtl/rx_timeout_cnt.sv | 37 +++
 rtl/word_rx_ctrl.sv | 111 +++++++++++
 tb/tb_word_rx_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/word_rx_ctrl_pkg.sv
// Shared definitions for the two-byte receive controller: state encoding,
// default timeout, and a saturating increment helper for the error counter.
package word_rx_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;  // waiting for the first byte of a pair
  localparam state_t ST_HALF = 2'd1;  // first byte loaded, waiting for the second
  localparam state_t ST_FULL = 2'd2;  // complete word presented to the consumer

  localparam int TIMEOUT_DEFAULT = 255;

  // Increment an 8-bit statistic, sticking at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/word_rx_ctrl_if.sv
// Byte-in / word-out handshake bundle, plus the load strobes that steer the
// external register pair. The controller sits on the slave side.
interface word_rx_ctrl_if;

  logic byte_valid;  // source offers a byte on the shared data bus
  logic byte_ready;  // controller takes the byte this cycle
  logic ld1;         // load strobe, high-byte register
  logic ld2;         // load strobe, low-byte register
  logic word_valid;  // register pair holds a complete word
  logic word_ready;  // consumer takes the word this cycle

  modport master (
    output byte_valid, word_ready,
    input  byte_ready, ld1, ld2, word_valid
  );

  modport slave (
    input  byte_valid, word_ready,
    output byte_ready, ld1, ld2, word_valid
  );

endinterface

// File: rtl/rx_timeout_cnt.sv
// Idle-cycle counter guarding the gap between the two bytes of a pair.
// expire is a plain decode of the count, so a byte arriving in the expiry
// cycle can still be honoured by the controller. TIMEOUT must be < 2**TO_W;
// TIMEOUT = 0 disables expiry altogether.
module rx_timeout_cnt
  import word_rx_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt;

  assign expire = (TIMEOUT != 0) && (cnt == LIMIT);

  // Count idle cycles; hold at the limit so the count never wraps past it.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/word_rx_ctrl.sv
// Sequencing controller for the reg1 (high) / reg2 (low) receive pair.
// Accepts bytes over a valid/ready handshake, fires ld1/ld2 in pair order,
// presents the assembled word with word_valid/word_ready, discards a stalled
// half pair on timeout, and keeps delivery/timeout statistics.
module word_rx_ctrl
  import word_rx_ctrl_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,             // 1: first byte -> ld1, second -> ld2
  parameter int TIMEOUT   = TIMEOUT_DEFAULT,  // idle cycles allowed mid-pair, 0 = off
  parameter int TO_W      = 8,                // timeout counter width
  parameter int CNT_W     = 16                // word_cnt width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  word_rx_ctrl_if.slave    bus,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] word_cnt,
  output logic [7:0]       err_cnt
);

  state_t state;
  state_t state_nxt;

  logic acc;          // byte handshake completes this cycle
  logic first_ld;     // acc loads the first slot of a pair
  logic second_ld;    // acc completes the pair
  logic deliver;      // consumer takes the word and it counts
  logic expire;       // idle budget exhausted this cycle
  logic timeout_hit;  // half pair actually discarded this cycle
  logic to_clear;
  logic to_enable;

  // Bytes are taken unless held in reset/clear or a pending word would be
  // overwritten; the FULL exit and a new first byte may share a cycle.
  assign bus.byte_ready = rst_n & ~clr & ((state != ST_FULL) | bus.word_ready);
  assign acc            = bus.byte_valid & bus.byte_ready;

  // Slot decode: the second slot is only ever loaded from HALF, so the two
  // strobes are mutually exclusive by construction.
  assign first_ld  = acc & (state != ST_HALF);
  assign second_ld = acc & (state == ST_HALF);
  assign bus.ld1   = MSB_FIRST ? first_ld  : second_ld;
  assign bus.ld2   = MSB_FIRST ? second_ld : first_ld;

  assign bus.word_valid = (state == ST_FULL);
  assign busy           = (state != ST_IDLE);

  assign deliver     = bus.word_valid & bus.word_ready & ~clr;
  // A second byte in the expiry cycle wins, and clear suppresses the error.
  assign timeout_hit = (state == ST_HALF) & ~acc & expire & ~clr;

  // The counter restarts whenever we are outside HALF, so it reads zero on
  // every entry to HALF, whether from IDLE or back-to-back from FULL.
  assign to_clear  = clr | (state != ST_HALF);
  assign to_enable = (state == ST_HALF) & ~acc;

  rx_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (to_clear),
    .enable (to_enable),
    .expire (expire)
  );

  // Next-state decode for the pair sequencer; clear overrides everything.
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no
    // latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (acc) state_nxt = ST_HALF;
      end
      ST_HALF: begin
        if (acc)         state_nxt = ST_FULL;
        else if (expire) state_nxt = ST_IDLE;
      end
      ST_FULL: begin
        if (bus.word_ready) state_nxt = acc ? ST_HALF : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clr) state_nxt = ST_IDLE;
  end

  // State, error pulse and statistics; clear zeroes counters and drops the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      err_timeout <= 1'b0;
      word_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      err_timeout <= timeout_hit;
      if (clr) begin
        word_cnt <= '0;
        err_cnt  <= '0;
      end else begin
        if (deliver)     word_cnt <= word_cnt + 1'b1;
        if (timeout_hit) err_cnt  <= sat_inc8(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_word_rx_ctrl.sv
// Self-checking bench for word_rx_ctrl. Two controllers (MSB_FIRST=1 and 0,
// TIMEOUT=4) share one stimulus stream and one data bus, each with its own
// register pair. A pair-level reference model predicts handshakes, strobes,
// status and counters every cycle and queues the expected words; a separate
// monitor pops and compares whenever a word is taken by the consumer.
module tb_word_rx_ctrl;

  localparam int TO = 4;

  typedef struct {
    logic [15:0] wa;  // expected word from the MSB-first instance
    logic [15:0] wb;  // expected word from the LSB-first instance
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       bv;
  logic       wr;
  logic [7:0] data_in;

  logic        busy_a, busy_b, err_a, err_b;
  logic [15:0] wcnt_a, wcnt_b;
  logic [7:0]  ecnt_a, ecnt_b;
  logic [7:0]  reg1_a, reg2_a, reg1_b, reg2_b;
  logic [15:0] data_out_a, data_out_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bytes held in the current pair, pending word, idle run.
  bit          m_half = 1'b0;
  bit          m_full = 1'b0;
  logic [7:0]  m_first = 8'h00;
  int          m_idle = 0;
  logic [15:0] m_wcnt = 16'h0;
  int          m_ecnt = 0;
  bit          m_err = 1'b0;
  exp_t        exp_q[$];

  word_rx_ctrl_if if_a ();
  word_rx_ctrl_if if_b ();

  assign if_a.byte_valid = bv;
  assign if_a.word_ready = wr;
  assign if_b.byte_valid = bv;
  assign if_b.word_ready = wr;

  word_rx_ctrl #(.MSB_FIRST(1'b1), .TIMEOUT(TO), .TO_W(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_a),
    .busy(busy_a), .err_timeout(err_a), .word_cnt(wcnt_a), .err_cnt(ecnt_a)
  );

  word_rx_ctrl #(.MSB_FIRST(1'b0), .TIMEOUT(TO), .TO_W(8), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_b),
    .busy(busy_b), .err_timeout(err_b), .word_cnt(wcnt_b), .err_cnt(ecnt_b)
  );

  // Register pairs sharing the data bus, loaded by each controller's strobes.
  always @(posedge clk) begin
    if (if_a.ld1) reg1_a <= data_in;
    if (if_a.ld2) reg2_a <= data_in;
    if (if_b.ld1) reg1_b <= data_in;
    if (if_b.ld2) reg2_b <= data_in;
  end
  assign data_out_a = {reg1_a, reg2_a};
  assign data_out_b = {reg1_b, reg2_b};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_half = 1'b0;
    m_full = 1'b0;
    m_idle = 0;
    m_wcnt = 16'h0;
    m_ecnt = 0;
    m_err  = 1'b0;
    exp_q.delete();
  endtask

  // Compare this cycle's outputs against the model, then advance the model
  // across the coming rising edge using the inputs now applied.
  task automatic model_step();
    bit br;
    bit acc;
    if (!rst_n) model_clear();
    br  = rst_n && !clr && (!m_full || wr);
    acc = bv && br;
    check("byte_ready_a", 32'(if_a.byte_ready), 32'(br));
    check("byte_ready_b", 32'(if_b.byte_ready), 32'(br));
    check("ld1_a", 32'(if_a.ld1), 32'(acc && !m_half));
    check("ld2_a", 32'(if_a.ld2), 32'(acc && m_half));
    check("ld1_b", 32'(if_b.ld1), 32'(acc && m_half));
    check("ld2_b", 32'(if_b.ld2), 32'(acc && !m_half));
    check("word_valid_a", 32'(if_a.word_valid), 32'(m_full));
    check("word_valid_b", 32'(if_b.word_valid), 32'(m_full));
    check("busy_a", 32'(busy_a), 32'(m_half || m_full));
    check("busy_b", 32'(busy_b), 32'(m_half || m_full));
    check("err_timeout_a", 32'(err_a), 32'(m_err));
    check("err_timeout_b", 32'(err_b), 32'(m_err));
    check("word_cnt_a", 32'(wcnt_a), 32'(m_wcnt));
    check("word_cnt_b", 32'(wcnt_b), 32'(m_wcnt));
    check("err_cnt_a", 32'(ecnt_a), 32'(m_ecnt));
    check("err_cnt_b", 32'(ecnt_b), 32'(m_ecnt));
    if (rst_n) begin
      if (clr) begin
        model_clear();
      end else begin
        m_err = 1'b0;
        if (m_full && wr) begin
          m_full = 1'b0;
          m_wcnt = m_wcnt + 16'h1;
        end
        if (m_half) begin
          if (acc) begin
            m_half = 1'b0;
            m_full = 1'b1;
            exp_q.push_back('{wa: {m_first, data_in}, wb: {data_in, m_first}});
          end else if (m_idle == TO) begin
            m_half = 1'b0;
            m_err  = 1'b1;
            if (m_ecnt < 255) m_ecnt++;
          end else begin
            m_idle++;
          end
        end else if (acc) begin
          m_half  = 1'b1;
          m_first = data_in;
          m_idle  = 0;
        end
      end
    end
  endtask

  // One clock cycle: drive inputs just after the falling edge, let them settle,
  // then check and advance the model before the next rising edge.
  task automatic tick(input bit r, input bit c, input bit v, input logic [7:0] d, input bit w);
    @(negedge clk);
    rst_n   = r;
    clr     = c;
    bv      = v;
    data_in = d;
    wr      = w;
    #1;
    model_step();
  endtask

  // Monitor: each word the consumer takes must match the next queued word.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n === 1'b1 && clr === 1'b0 && if_a.word_valid === 1'b1 && wr === 1'b1) begin
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data_out_a", 32'(data_out_a), 32'(e.wa));
        check("data_out_b", 32'(data_out_b), 32'(e.wb));
      end
    end
  end

  initial begin
    int seen;
    int rate;
    rst_n   = 1'b1;
    clr     = 1'b0;
    bv      = 1'b0;
    wr      = 1'b0;
    data_in = 8'h00;

    tick(0, 0, 0, 8'h00, 0);
    tick(0, 0, 1, 8'hFF, 1);
    tick(1, 0, 0, 8'h00, 0);

    // Single pair with an always-ready consumer.
    tick(1, 0, 1, 8'hA5, 1);
    tick(1, 0, 1, 8'h3C, 1);
    tick(1, 0, 0, 8'h00, 1);
    check("t1_word_valid", 32'(if_a.word_valid), 32'd1);
    check("t1_data_out", 32'(data_out_a), 32'hA53C);
    tick(1, 0, 0, 8'h00, 1);
    check("t1_word_cnt", 32'(wcnt_a), 32'd1);

    // Backpressure with a third byte waiting.
    tick(1, 0, 1, 8'hA5, 0);
    tick(1, 0, 1, 8'h3C, 0);
    for (int k = 0; k < 5; k++) begin
      tick(1, 0, 1, 8'h11, 0);
      check("t2_stall_ready", 32'(if_a.byte_ready), 32'd0);
      check("t2_held_data", 32'(data_out_a), 32'hA53C);
    end
    tick(1, 0, 1, 8'h11, 1);
    check("t2_release_ld1", 32'(if_a.ld1), 32'd1);
    tick(1, 0, 1, 8'h22, 1);
    check("t2_half_busy", 32'(busy_a), 32'd1);
    tick(1, 0, 0, 8'h00, 1);
    check("t2_second_word", 32'(data_out_a), 32'h1122);

    // Timeout after a lone first byte.
    tick(1, 0, 0, 8'h00, 1);
    tick(1, 0, 1, 8'h77, 1);
    seen = 0;
    for (int j = 1; j <= 8; j++) begin
      tick(1, 0, 0, 8'h00, 1);
      if (err_a === 1'b1 && seen == 0) seen = j;
    end
    check("t3_pulse_cycle", 32'(seen), 32'(TO + 2));
    check("t3_idle", 32'(busy_a), 32'd0);

    // Second byte exactly in the expiry cycle.
    tick(1, 0, 1, 8'h77, 1);
    for (int j = 0; j < TO; j++) tick(1, 0, 0, 8'h00, 1);
    tick(1, 0, 1, 8'h99, 1);
    check("t4_race_ld2", 32'(if_a.ld2), 32'd1);
    tick(1, 0, 0, 8'h00, 1);
    check("t4_race_word", 32'(data_out_a), 32'h7799);

    // Clear in HALF, then asynchronous reset while FULL.
    tick(1, 0, 1, 8'h55, 1);
    tick(1, 1, 1, 8'h66, 1);
    tick(1, 0, 0, 8'h00, 1);
    check("t5_clr_idle", 32'(busy_a), 32'd0);
    tick(1, 0, 1, 8'h66, 0);
    tick(1, 0, 1, 8'h77, 0);
    tick(1, 0, 0, 8'h00, 0);
    tick(0, 0, 0, 8'h00, 0);
    check("t5_async_reset", 32'(if_a.word_valid), 32'd0);
    tick(1, 0, 0, 8'h00, 1);
    tick(1, 0, 1, 8'h12, 1);
    tick(1, 0, 1, 8'h34, 1);
    tick(1, 0, 0, 8'h00, 1);
    check("t5_after_reset", 32'(data_out_a), 32'h1234);

    // LSB-first instance: 0x34 then 0x12 assembles 0x1234.
    tick(1, 0, 1, 8'h34, 1);
    tick(1, 0, 1, 8'h12, 1);
    tick(1, 0, 0, 8'h00, 1);
    check("t6_lsb_first", 32'(data_out_b), 32'h1234);

    // Drive err_cnt into saturation.
    tick(1, 1, 0, 8'h00, 1);
    for (int i = 0; i < 258; i++) begin
      tick(1, 0, 1, 8'(i), 1);
      for (int j = 0; j < TO + 2; j++) tick(1, 0, 0, 8'h00, 1);
    end
    check("err_cnt_saturated", 32'(ecnt_a), 32'd255);

    // Randomized traffic with varying byte density, occasional clear and reset.
    rate = 60;
    for (int n = 0; n < 4000; n++) begin
      if (n % 64 == 0) begin
        case ($urandom_range(2))
          0:       rate = 10;
          1:       rate = 60;
          default: rate = 95;
        endcase
      end
      tick(($urandom_range(799) != 0),
           ($urandom_range(99) == 0),
           ($urandom_range(99) < rate),
           8'($urandom),
           ($urandom_range(1) == 1));
    end

    // Drain any pending word and let a half pair time out.
    for (int j = 0; j < TO + 4; j++) tick(1, 0, 0, 8'h00, 1);
    #5;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
